mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_arb_priority.sv | 36 +++
 rtl/mem_arbiter.sv | 79 +++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WEB_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IM_WAIT = 2'd1,
    ARB_DM_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IM = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and shared memory port.
// master: requesters and memory model side; slave: the arbiter.
interface mem_arbiter_if;

  logic                            im_req;
  logic [mem_arb_pkg::ADDR_W-1:0]  im_addr;
  logic                            im_ready;
  logic [mem_arb_pkg::DATA_W-1:0]  im_rdata;

  logic                            dm_req;
  logic [mem_arb_pkg::ADDR_W-1:0]  dm_addr;
  logic [mem_arb_pkg::DATA_W-1:0]  dm_wdata;
  logic [mem_arb_pkg::WEB_W-1:0]   dm_web;
  logic                            dm_ready;
  logic [mem_arb_pkg::DATA_W-1:0]  dm_rdata;

  logic                            mem_ce;
  logic [mem_arb_pkg::ADDR_W-1:0]  mem_addr;
  logic [mem_arb_pkg::DATA_W-1:0]  mem_wdata;
  logic [mem_arb_pkg::WEB_W-1:0]   mem_web;
  logic [mem_arb_pkg::DATA_W-1:0]  mem_rdata;

  modport master (
    output im_req, im_addr, dm_req, dm_addr, dm_wdata, dm_web, mem_rdata,
    input  im_ready, im_rdata, dm_ready, dm_rdata,
           mem_ce, mem_addr, mem_wdata, mem_web
  );

  modport slave (
    input  im_req, im_addr, dm_req, dm_addr, dm_wdata, dm_web, mem_rdata,
    output im_ready, im_rdata, dm_ready, dm_rdata,
           mem_ce, mem_addr, mem_wdata, mem_web
  );

endinterface

// File: rtl/mem_arbiter_arb_priority.sv
// Combinational grant selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN defined: conflicts go to the requester not granted last.
// Default: fixed priority, data port wins every conflict.
module arb_priority
  import mem_arb_pkg::*;
(
  input  logic   im_req,
  input  logic   dm_req,
  input  grant_e last_grant,
  output grant_e grant
);

`ifdef ARB_ROUND_ROBIN_EN
  // On conflict favour whoever did not win the previous grant.
  always_comb begin
    grant = GNT_IM;
    if (im_req && dm_req) begin
      grant = (last_grant == GNT_IM) ? GNT_DM : GNT_IM;
    end else if (dm_req) begin
      grant = GNT_DM;
    end
  end
`else
  logic last_grant_unused;
  assign last_grant_unused = (last_grant == GNT_DM) & im_req;

  // Data port always wins; fetch only when data port is quiet.
  always_comb begin
    grant = GNT_IM;
    if (dm_req) begin
      grant = GNT_DM;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency memory.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin conflict resolution
// (see arb_priority); default is fixed data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e state, state_nxt;
  grant_e     last_grant, last_grant_nxt;
  grant_e     grant;

  arb_priority u_arb_priority (
    .im_req     (bus.im_req),
    .dm_req     (bus.dm_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // State and last-grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_IM;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next state and outputs; everything is held at zero while rst is high,
  // which also suppresses the ready of an access aborted by reset.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    bus.mem_ce     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_web    = '0;
    bus.im_ready   = 1'b0;
    bus.im_rdata   = '0;
    bus.dm_ready   = 1'b0;
    bus.dm_rdata   = '0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (bus.im_req || bus.dm_req) begin
            bus.mem_ce     = 1'b1;
            last_grant_nxt = grant;
            if (grant == GNT_DM) begin
              bus.mem_addr  = bus.dm_addr;
              bus.mem_wdata = bus.dm_wdata;
              bus.mem_web   = bus.dm_web;
              state_nxt     = ARB_DM_WAIT;
            end else begin
              bus.mem_addr  = bus.im_addr;
              state_nxt     = ARB_IM_WAIT;
            end
          end
        end
        ARB_IM_WAIT: begin
          bus.im_ready = 1'b1;
          bus.im_rdata = bus.mem_rdata;
          state_nxt    = ARB_IDLE;
        end
        ARB_DM_WAIT: begin
          bus.dm_ready = 1'b1;
          bus.dm_rdata = bus.mem_rdata;
          state_nxt    = ARB_IDLE;
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus events,
// a negedge monitor pops and compares whenever the arbiter shows activity.
module tb_mem_arbiter;

  localparam int K_ISS = 0;
  localparam int K_IM  = 1;
  localparam int K_DM  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  web;
    logic [31:0] rdata;
    bit          chk_rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] web,
                      input logic [31:0] rdata, input bit chk);
    exp_t e;
    e.kind = kind; e.addr = addr; e.wdata = wdata; e.web = web;
    e.rdata = rdata; e.chk_rdata = chk;
    q.push_back(e);
  endtask

  task automatic check_quiet(input string name);
    bit ok;
    ok = !bus.mem_ce && !bus.im_ready && !bus.dm_ready &&
         bus.mem_addr == 32'h0 && bus.mem_wdata == 32'h0 && bus.mem_web == 4'h0 &&
         bus.im_rdata == 32'h0 && bus.dm_rdata == 32'h0;
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: ce=%b im_rdy=%b dm_rdy=%b addr=%h wdata=%h web=%b im_rdata=%h dm_rdata=%h, required all zero",
                  name, bus.mem_ce, bus.im_ready, bus.dm_ready, bus.mem_addr,
                  bus.mem_wdata, bus.mem_web, bus.im_rdata, bus.dm_rdata);
  endtask

  // Monitor: compare every active cycle against the head of the queue.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!rst && !done) begin
        if (bus.mem_ce || bus.im_ready || bus.dm_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_event: ce=%b im_rdy=%b dm_rdy=%b addr=%h, required no activity",
                     bus.mem_ce, bus.im_ready, bus.dm_ready, bus.mem_addr);
          end else begin
            e = q.pop_front();
            case (e.kind)
              K_ISS: ok = bus.mem_ce && !bus.im_ready && !bus.dm_ready &&
                          bus.mem_addr == e.addr && bus.mem_wdata == e.wdata &&
                          bus.mem_web == e.web &&
                          bus.im_rdata == 32'h0 && bus.dm_rdata == 32'h0;
              K_IM:  ok = !bus.mem_ce && bus.im_ready && !bus.dm_ready &&
                          bus.im_rdata == e.rdata && bus.dm_rdata == 32'h0;
              default: ok = !bus.mem_ce && !bus.im_ready && bus.dm_ready &&
                          (!e.chk_rdata || bus.dm_rdata == e.rdata) &&
                          bus.im_rdata == 32'h0;
            endcase
            if (ok) n_pass++;
            else $display("FAIL event_kind%0d: ce=%b im_rdy=%b dm_rdy=%b addr=%h wdata=%h web=%b im_rdata=%h dm_rdata=%h, required addr=%h wdata=%h web=%b rdata=%h",
                          e.kind, bus.mem_ce, bus.im_ready, bus.dm_ready, bus.mem_addr,
                          bus.mem_wdata, bus.mem_web, bus.im_rdata, bus.dm_rdata,
                          e.addr, e.wdata, e.web, e.rdata);
          end
        end else begin
          check_quiet("idle_outputs");
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bus.im_req = 1'b1; bus.im_addr = 32'h0;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0; bus.dm_web = 4'h0;
    bus.mem_rdata = 32'hFFFF_FFFF;

    // Reset with both requests raised: outputs must stay zero.
    tick();
    @(negedge clk);
    check_quiet("reset_outputs");
    tick();
    bus.im_req = 1'b0; bus.dm_req = 1'b0;
    rst = 1'b0;
    tick();

    // Fetch alone.
    bus.mem_rdata = 32'hDEAD_BEEF;
    push(K_ISS, 32'h100, 32'h0, 4'h0, 32'h0, 1'b0);
    push(K_IM,  32'h0,   32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
    bus.im_req = 1'b1; bus.im_addr = 32'h100;
    tick();
    bus.im_req = 1'b0;
    tick(); tick();

    // Data write.
    push(K_ISS, 32'h2004, 32'h1234, 4'b0011, 32'h0, 1'b0);
    push(K_DM,  32'h0,    32'h0,    4'h0,    32'h0, 1'b0);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h2004; bus.dm_wdata = 32'h1234; bus.dm_web = 4'b0011;
    tick();
    bus.dm_req = 1'b0;
    tick(); tick();

    // Data read.
    bus.mem_rdata = 32'hCAFE_F00D;
    push(K_ISS, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
    push(K_DM,  32'h0,  32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h0; bus.dm_web = 4'h0;
    tick();
    bus.dm_req = 1'b0;
    tick(); tick();

    // Conflict held for 8 cycles, starting from a fresh reset (last grant IM).
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.mem_rdata = 32'h0000_55AA;
    for (int unsigned g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (g % 2 == 0) begin
        push(K_ISS, 32'h400, 32'h0, 4'h0, 32'h0, 1'b0);
        push(K_DM,  32'h0,   32'h0, 4'h0, 32'h55AA, 1'b1);
      end else begin
        push(K_ISS, 32'h300, 32'h0, 4'h0, 32'h0, 1'b0);
        push(K_IM,  32'h0,   32'h0, 4'h0, 32'h55AA, 1'b1);
      end
`else
      push(K_ISS, 32'h400, 32'h0, 4'h0, 32'h0, 1'b0);
      push(K_DM,  32'h0,   32'h0, 4'h0, 32'h55AA, 1'b1);
`endif
    end
    bus.im_req = 1'b1; bus.im_addr = 32'h300;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h400;
    repeat (8) tick();
    bus.im_req = 1'b0; bus.dm_req = 1'b0;
    tick(); tick();

    // Reset during IM_WAIT aborts the fetch; next grant is a fresh request.
    push(K_ISS, 32'h500, 32'h0, 4'h0, 32'h0, 1'b0);
    bus.im_req = 1'b1; bus.im_addr = 32'h500;
    tick();
    rst = 1'b1; bus.im_req = 1'b0;
    @(negedge clk);
    check_quiet("reset_in_im_wait");
    tick();
    rst = 1'b0;
    bus.mem_rdata = 32'h0000_0600;
    push(K_ISS, 32'h600, 32'h0, 4'h0, 32'h0, 1'b0);
    push(K_DM,  32'h0,   32'h0, 4'h0, 32'h0000_0600, 1'b1);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h600; bus.dm_web = 4'h0;
    tick();
    bus.dm_req = 1'b0;
    tick(); tick();

    // dm_req dropped during DM_WAIT; a fetch raised right after must issue at once.
    bus.mem_rdata = 32'h0BAD_CAFE;
    push(K_ISS, 32'h700, 32'h0, 4'h0, 32'h0, 1'b0);
    push(K_DM,  32'h0,   32'h0, 4'h0, 32'h0BAD_CAFE, 1'b1);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h700;
    tick();
    bus.dm_req = 1'b0;
    tick();
    push(K_ISS, 32'h800, 32'h0, 4'h0, 32'h0, 1'b0);
    push(K_IM,  32'h0,   32'h0, 4'h0, 32'h0BAD_CAFE, 1'b1);
    bus.im_req = 1'b1; bus.im_addr = 32'h800;
    tick();
    bus.im_req = 1'b0;
    repeat (3) tick();

    // Every expected event must have been observed.
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_expectations: %0d left, required 0", q.size());

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
